// File: rtl/multi_channel_chunk_processor.sv
// Per chunk_pulse, walks an interleaved multi-channel buffer slot by slot, sends each sample
// through an external filter core (or copies it in bypass mode) and writes the result in place.
module multi_channel_chunk_processor #(
  parameter int SAMPLE_SIZE = 24,
  parameter int NUM_CH      = 2,
  parameter int CHUNK_LEN   = 64,
  parameter int START_DELAY = 64,
  parameter int TIMEOUT     = 1024,
  parameter int BUFF_DEPTH  = NUM_CH * CHUNK_LEN,
  parameter int PTR_BITS    = (BUFF_DEPTH > 1) ? $clog2(BUFF_DEPTH) : 1,
  parameter int CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   chunk_pulse,
  input  logic                   bypass,
  output logic [PTR_BITS-1:0]    input_buff_ptr,
  input  logic [SAMPLE_SIZE-1:0] input_buff_sample,
  output logic [PTR_BITS-1:0]    output_buff_ptr,
  output logic [SAMPLE_SIZE-1:0] output_buff_sample,
  output logic                   output_buff_write_pulse,
  output logic [SAMPLE_SIZE-1:0] filt_din,
  output logic [CH_BITS-1:0]     filt_ch,
  output logic                   filt_nd,
  input  logic                   filt_rfd,
  input  logic                   filt_rdy,
  input  logic [SAMPLE_SIZE-1:0] filt_dout,
  output logic                   busy,
  output logic                   chunk_done,
  output logic                   overrun,
  output logic                   timeout_err,
  output logic [2:0]             dbg_state
);

  localparam int CNT_MAX  = (START_DELAY > TIMEOUT) ? START_DELAY : TIMEOUT;
  localparam int CNT_BITS = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_BITS-1:0] DELAY_LAST = CNT_BITS'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [CNT_BITS-1:0] TO_LAST    = CNT_BITS'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PTR_BITS-1:0] PTR_LAST   = PTR_BITS'(BUFF_DEPTH - 1);
  localparam logic [CH_BITS-1:0]  CH_LAST    = CH_BITS'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_BITS-1:0]    ptr_q, ptr_d;
  logic [CH_BITS-1:0]     ch_q, ch_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   byp_q, byp_d;
  logic [SAMPLE_SIZE-1:0] sample_q, sample_d;
  logic                   terr_q, terr_d;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    byp_d    = byp_q;
    sample_d = sample_q;
    terr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (chunk_pulse) begin
          byp_d   = bypass;
          state_d = (START_DELAY > 0) ? S_DELAY : S_ISSUE;
        end
      end
      S_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (byp_q) begin
          sample_d = input_buff_sample;
          state_d  = S_WRITE;
        end else if (filt_rfd) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // An unanswered sample is written as zero so the chunk keeps its slot alignment.
        if (filt_rdy) begin
          sample_d = filt_dout;
          cnt_d    = '0;
          state_d  = S_WRITE;
        end else if (cnt_q == TO_LAST) begin
          sample_d = '0;
          terr_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        // Explicit wrap keeps the pointer in range for non-power-of-two depths.
        if (ptr_q == PTR_LAST) begin
          ptr_d   = '0;
          ch_d    = '0;
          state_d = S_IDLE;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      byp_q    <= 1'b0;
      sample_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      byp_q    <= byp_d;
      sample_q <= sample_d;
      terr_q   <= terr_d;
    end
  end

  // Filter handshake: filt_nd is the valid for filt_din/filt_ch and is raised only in a cycle
  // where filt_rfd (ready) is high, so a transfer happens exactly when filt_nd is 1; filt_rdy is
  // the result valid, has no backpressure, and is consumed only while waiting for a result.
  assign filt_nd                 = (state_q == S_ISSUE) && !byp_q && filt_rfd;
  assign filt_din                = input_buff_sample;
  assign filt_ch                 = ch_q;
  assign input_buff_ptr          = ptr_q;
  assign output_buff_ptr         = ptr_q;
  assign output_buff_sample      = sample_q;
  assign output_buff_write_pulse = (state_q == S_WRITE);
  assign chunk_done              = (state_q == S_WRITE) && (ptr_q == PTR_LAST);
  assign busy                    = (state_q != S_IDLE);
  assign overrun                 = chunk_pulse && (state_q != S_IDLE);
  assign timeout_err             = terr_q;
  assign dbg_state               = state_q;

endmodule

// File: tb/tb_multi_channel_chunk_processor.sv
// Bench for multi_channel_chunk_processor: filter model, per-chunk expected-write queue and
// cycle-level busy/overrun model, driven by directed and randomized chunks.
module tb_multi_channel_chunk_processor;

  localparam int W   = 24;
  localparam int NCH = 2;
  localparam int CLEN = 4;
  localparam int SD  = 64;
  localparam int TO  = 16;
  localparam int BD  = NCH * CLEN;
  localparam int PB  = 3;
  localparam int CB  = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          chunk_pulse = 1'b0;
  logic          bypass = 1'b0;
  logic [PB-1:0] input_buff_ptr, output_buff_ptr;
  logic [W-1:0]  input_buff_sample, output_buff_sample, filt_din;
  logic [W-1:0]  filt_dout = '0;
  logic          output_buff_write_pulse, filt_nd, busy, chunk_done, overrun, timeout_err;
  logic          filt_rfd = 1'b0;
  logic          filt_rdy = 1'b0;
  logic [CB-1:0] filt_ch;
  logic [2:0]    dbg_state;

  logic [W-1:0] in_mem [BD];
  logic [W-1:0] out_mem [BD];
  assign input_buff_sample = in_mem[input_buff_ptr];

  multi_channel_chunk_processor #(
    .SAMPLE_SIZE(W), .NUM_CH(NCH), .CHUNK_LEN(CLEN), .START_DELAY(SD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst_n), .chunk_pulse(chunk_pulse), .bypass(bypass),
    .input_buff_ptr(input_buff_ptr), .input_buff_sample(input_buff_sample),
    .output_buff_ptr(output_buff_ptr), .output_buff_sample(output_buff_sample),
    .output_buff_write_pulse(output_buff_write_pulse),
    .filt_din(filt_din), .filt_ch(filt_ch), .filt_nd(filt_nd), .filt_rfd(filt_rfd),
    .filt_rdy(filt_rdy), .filt_dout(filt_dout),
    .busy(busy), .chunk_done(chunk_done), .overrun(overrun), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // ---------------- shared model state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  string lit_name_q[$];
  int    lit_act_q[$];
  int    lit_exp_q[$];

  int cur_l = 3;
  int chunk_hang = -1;
  int rfd_mode = 1;
  int rfd_lo = -1;
  int rfd_hi = -1;

  bit model_busy = 0;
  bit lat_byp = 0;
  bit outstanding = 0;
  bit nd_hang = 0;
  int acc_cyc = 0, done_cyc = 0, nd_cyc = 0, first_nd_cyc = 0, nd3_cyc = 0, w3_cyc = 0;
  int wr_idx = 0, nd_idx = 0, nd_cnt = 0;
  int nd_evt = 0;
  int terr_cnt = 0, ovr_cnt = 0;
  logic [W-1:0] nd_val = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    lit_name_q.push_back(name);
    lit_act_q.push_back(act);
    lit_exp_q.push_back(exp);
  endtask

  // ---------------- filter model and rfd driver ----------------
  int  seen_evt = 0;
  bit  pend = 0;
  int  rem = 0;
  logic [W-1:0] pval = '0;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pend = 0;
      seen_evt = nd_evt;
      filt_rdy = 1'b0;
      filt_rfd = 1'b0;
    end else begin
      if (nd_evt != seen_evt) begin
        seen_evt = nd_evt;
        pend = !nd_hang;
        rem = cur_l;
        pval = nd_val + 1'b1;
      end
      filt_rdy = 1'b0;
      filt_dout = W'($urandom);
      if (pend) begin
        rem--;
        if (rem == 0) begin
          filt_rdy = 1'b1;
          filt_dout = pval;
          pend = 0;
        end
      end else if (!outstanding && $urandom_range(0, 3) == 0) begin
        filt_rdy = 1'b1;
      end
      if (cyc >= rfd_lo && cyc <= rfd_hi) filt_rfd = 1'b0;
      else if (rfd_mode == 1) filt_rfd = 1'b1;
      else filt_rfd = ($urandom_range(0, 9) < 7);
    end
  end

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    bit busy_now;
    logic [W-1:0] e;
    busy_now = model_busy;
    if (!rst_n) begin
      check("rst_in_ptr", int'(input_buff_ptr), 0);
      check("rst_out_ptr", int'(output_buff_ptr), 0);
      check("rst_out_sample", int'(output_buff_sample), 0);
      check("rst_write", int'(output_buff_write_pulse), 0);
      check("rst_nd", int'(filt_nd), 0);
      check("rst_ch", int'(filt_ch), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(chunk_done), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_terr", int'(timeout_err), 0);
      model_busy = 0;
      exp_q.delete();
      wr_idx = 0;
      nd_idx = 0;
      outstanding = 0;
    end else begin
      while (lit_name_q.size() > 0)
        check(lit_name_q.pop_front(), lit_act_q.pop_front(), lit_exp_q.pop_front());
      check("busy", int'(busy), int'(busy_now));
      check("overrun", int'(overrun), int'(chunk_pulse && busy_now));
      if (overrun) ovr_cnt++;
      if (timeout_err) terr_cnt++;
      if (filt_nd) begin
        check("nd_while_idle", int'(busy_now), 1);
        check("nd_in_bypass", int'(lat_byp), 0);
        check("nd_without_rfd", int'(filt_rfd), 1);
        check("nd_twice", int'(outstanding), 0);
        check("nd_ptr", int'(input_buff_ptr), nd_idx);
        check("nd_ch", int'(filt_ch), nd_idx % NCH);
        check("nd_din", int'(filt_din), int'(in_mem[nd_idx % BD]));
        if (nd_idx == 0) first_nd_cyc = cyc;
        if (nd_idx == 3) nd3_cyc = cyc;
        nd_hang = (nd_idx == chunk_hang);
        nd_val = filt_din;
        nd_cyc = cyc;
        nd_evt++;
        outstanding = 1;
        nd_idx++;
        nd_cnt++;
      end
      if (output_buff_write_pulse) begin
        if (exp_q.size() == 0) begin
          check("write_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_ptr", int'(output_buff_ptr), wr_idx);
          check("wr_ptr_match", int'(input_buff_ptr), wr_idx);
          check("wr_data", int'(output_buff_sample), int'(e));
          check("wr_done", int'(chunk_done), int'(wr_idx == BD - 1));
          check("wr_terr", int'(timeout_err), int'(!lat_byp && wr_idx == chunk_hang));
          if (lat_byp) begin
            check("byp_latency", cyc - acc_cyc, SD + 2 * (wr_idx + 1));
          end else begin
            check("wr_without_nd", int'(outstanding), 1);
            check("proc_latency", cyc - nd_cyc, (nd_hang ? TO : cur_l) + 1);
          end
          out_mem[output_buff_ptr] = output_buff_sample;
          if (wr_idx == 3) w3_cyc = cyc;
          if (wr_idx == BD - 1) begin
            model_busy = 0;
            done_cyc = cyc;
          end
          wr_idx++;
          outstanding = 0;
        end
      end else begin
        check("done_no_write", int'(chunk_done), 0);
        check("terr_no_write", int'(timeout_err), 0);
      end
      if (chunk_pulse && !busy_now) begin
        lat_byp = bypass;
        acc_cyc = cyc;
        wr_idx = 0;
        nd_idx = 0;
        nd_cnt = 0;
        model_busy = 1;
        exp_q.delete();
        for (int i = 0; i < BD; i++) begin
          if (bypass) e = in_mem[i];
          else if (i == chunk_hang) e = '0;
          else e = in_mem[i] + 1'b1;
          exp_q.push_back(e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < BD; i++) in_mem[i] = W'($urandom);
  endtask

  task automatic start_chunk(input bit byp);
    chunk_pulse = 1'b1;
    bypass = byp;
    step();
    chunk_pulse = 1'b0;
    bypass = 1'($urandom);
  endtask

  task automatic wait_done(input bit rand_ovr);
    int g;
    g = 0;
    while (model_busy && g < 3000) begin
      chunk_pulse = rand_ovr && ($urandom_range(0, 39) == 0);
      step();
      g++;
    end
    chunk_pulse = 1'b0;
    if (g >= 3000) lit("chunk_never_finished", 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start, ovr0, terr0, g;
    for (int i = 0; i < BD; i++) in_mem[i] = '0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // A: filter path, L=3, overrun in DELAY and in the chunk_done cycle
    for (int i = 0; i < BD; i++) in_mem[i] = W'(32'h100 + i);
    cur_l = 3; rfd_mode = 1; chunk_hang = -1;
    ovr0 = ovr_cnt;
    start = cyc;
    start_chunk(1'b0);
    while (cyc < start + 10) step();
    chunk_pulse = 1'b1; step(); chunk_pulse = 1'b0;
    while (cyc < start + 104 && model_busy) step();
    chunk_pulse = 1'b1; step(); chunk_pulse = 1'b0;
    wait_done(1'b0);
    lit("a_done_latency", done_cyc - start, 104);
    lit("a_overrun_count", ovr_cnt - ovr0, 2);
    lit("a_out0", int'(out_mem[0]), 32'h101);
    lit("a_out7", int'(out_mem[7]), 32'h108);
    step();

    // B: bypass chunk, accepted from IDLE right after the overruns
    fill_random();
    rfd_mode = 0;
    start = cyc;
    start_chunk(1'b1);
    wait_done(1'b0);
    lit("b_done_latency", done_cyc - start, 80);
    lit("b_nd_count", nd_cnt, 0);
    lit("b_out5", int'(out_mem[5]), int'(in_mem[5]));
    step();

    // C: rfd held low for the first 10 ISSUE cycles
    fill_random();
    cur_l = 2; rfd_mode = 1;
    start = cyc;
    rfd_lo = start + 65; rfd_hi = start + 74;
    start_chunk(1'b0);
    wait_done(1'b0);
    lit("c_first_nd", first_nd_cyc - start, 75);
    rfd_lo = -1; rfd_hi = -1;
    step();

    // D: filter never answers slot 3
    fill_random();
    cur_l = 4; rfd_mode = 1; chunk_hang = 3;
    terr0 = terr_cnt;
    start_chunk(1'b0);
    wait_done(1'b0);
    lit("d_slot3_zero", int'(out_mem[3]), 0);
    lit("d_terr_count", terr_cnt - terr0, 1);
    lit("d_slot3_latency", w3_cyc - nd3_cyc, 17);
    lit("d_slot4", int'(out_mem[4]), int'(in_mem[4] + 1'b1));
    chunk_hang = -1;
    step();

    // E: asynchronous reset mid-chunk, then a fresh chunk from slot 0
    fill_random();
    cur_l = 3; rfd_mode = 0;
    start_chunk(1'b0);
    g = 0;
    while (wr_idx < 3 && g < 2000) begin step(); g++; end
    if (g >= 2000) lit("e_no_progress", 1, 0);
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    fill_random();
    start_chunk(1'($urandom));
    wait_done(1'b1);

    // F: randomized chunks with stray chunk_pulses while busy
    for (int k = 0; k < 6; k++) begin
      fill_random();
      if (k == 0) in_mem[BD - 1] = '1;
      cur_l = $urandom_range(1, 5);
      chunk_hang = ($urandom_range(0, 3) == 0) ? $urandom_range(0, BD - 1) : -1;
      rfd_mode = $urandom_range(0, 1);
      repeat ($urandom_range(0, 3)) step();
      start_chunk($urandom_range(0, 3) == 0);
      wait_done(1'b1);
    end
    chunk_hang = -1;

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
